// File: rtl/spr_pkg.sv
// Shared SPR pipeline definitions: pixel/beat geometry and lane offsets.
// Imported by the input packer and the re-gamma stage.
package spr_pkg;

  localparam int PIX_W       = 10;
  localparam int PIXEL_W     = 3 * PIX_W;
  localparam int PPB         = 4;
  localparam int BEAT_W      = PPB * PIXEL_W;
  localparam int GAMMA_OUT_W = 11;

  localparam int R_LSB = 0;
  localparam int G_LSB = PIX_W;
  localparam int B_LSB = 2 * PIX_W;

  // LSB of pixel lane n within a packed beat.
  function automatic int pix_lsb(input int n);
    return n * PIXEL_W;
  endfunction

endpackage

// File: rtl/spr_sync_dly.sv
// Delay line for {hs,vs} with DEPTH register stages; latency DEPTH cycles.
// No backpressure: shifts every clock.
module spr_sync_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_hs,
  input  logic i_vs,
  output logic o_hs,
  output logic o_vs
);

  logic [1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= 2'b00;
    end else begin
      sr_q[0] <= {i_hs, i_vs};
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign o_hs = sr_q[DEPTH-1][1];
  assign o_vs = sr_q[DEPTH-1][0];

endmodule

// File: rtl/spr_pixel_pack.sv
// Packs 1 pixel/clk into 4-pixel beats, edge-replicating partial beats at line end.
// Latency 1 cycle (beat and syncs); never stalls, no backpressure.
module spr_pixel_pack
  import spr_pkg::*;
#(
  parameter int PIX_W  = 10,
  parameter int XCNT_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_de,
  input  logic [3*PIX_W-1:0]  i_pix,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic [12*PIX_W-1:0] o_pix,
  output logic [1:0]          o_pad,
  output logic [XCNT_W-1:0]   o_x,
  output logic                o_err
);

  localparam int LANE_W = 3 * PIX_W;

  logic [LANE_W-1:0]   slot_q [PPB];
  logic [1:0]          s_q;
  logic                de_q;
  logic [XCNT_W-1:0]   bcnt_q;

  logic                sync;
  logic                proto_err;
  logic                full_beat;
  logic                flush_beat;
  logic [LANE_W-1:0]   last_pix;
  logic [12*PIX_W-1:0] beat_dat;

  assign sync       = i_hs | i_vs;
  assign proto_err  = i_de & sync;
  // A sync inside active video abandons the partial beat, so no full beat either.
  assign full_beat  = i_de & ~sync & (s_q == 2'd3);
  assign flush_beat = ~i_de & de_q & (s_q != 2'd0);
  assign last_pix   = slot_q[s_q - 2'd1];

  always_comb begin
    beat_dat = '0;
    for (int j = 0; j < PPB; j++) begin
      if (full_beat)
        beat_dat[j*LANE_W +: LANE_W] = (j == PPB - 1) ? i_pix : slot_q[j];
      else if (2'(j) < s_q)
        beat_dat[j*LANE_W +: LANE_W] = slot_q[j];
      else
        beat_dat[j*LANE_W +: LANE_W] = last_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PPB; k++) slot_q[k] <= '0;
      s_q    <= 2'd0;
      de_q   <= 1'b0;
      bcnt_q <= '0;
      o_de   <= 1'b0;
      o_pix  <= '0;
      o_pad  <= 2'd0;
      o_x    <= '0;
      o_err  <= 1'b0;
    end else begin
      de_q <= i_de;
      if (i_de) begin
        slot_q[s_q] <= i_pix;
        s_q         <= proto_err ? 2'd0 : s_q + 2'd1;
      end else if (flush_beat) begin
        s_q <= 2'd0;
      end

      o_de <= full_beat | flush_beat;
      if (full_beat | flush_beat) begin
        o_pix <= beat_dat;
        o_pad <= full_beat ? 2'd0 : 2'd0 - s_q;
        o_x   <= bcnt_q;
      end

      // Clear wins so a flush coinciding with the next line's hs still starts at 0.
      if (sync)
        bcnt_q <= '0;
      else if (full_beat | flush_beat)
        bcnt_q <= bcnt_q + XCNT_W'(1);

      if (proto_err) o_err <= 1'b1;
    end
  end

  spr_sync_dly #(.DEPTH(1)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_hs  (i_hs),
    .i_vs  (i_vs),
    .o_hs  (o_hs),
    .o_vs  (o_vs)
  );

endmodule
